// File: rtl/win_checker.sv
// win_checker: shadows the Connect Four board from column writes and walks
// outward from each new piece to report a win or a draw.
module win_checker (
  input  logic       clk,
  input  logic       reset,
  input  logic       logic_reset,
  input  logic       logic_go,
  input  logic [2:0] mem_address,
  input  logic [5:0] write_to_onoff,
  input  logic [5:0] write_to_player,
  output logic       logic_result,
  output logic       logic_done,
  output logic       logic_busy,
  output logic       winner,
  output logic       draw
);
  typedef enum logic [1:0] {IDLE, LOAD, PROBE, DONE} state_t;
  state_t state, next;
  logic clr, skip, on_board, match, win_hit, scan_end, full, pp, neg;
  logic [7:0][5:0] onoff_sh, player_sh;
  logic [2:0] addr_q, p, cnt;
  logic [5:0] on_q, pl_q;
  logic [1:0] d;
  logic signed [3:0] pc, pr, pos_c, pos_r, dc, dr, dc_n, dr_n, sc, sr;
  function automatic logic signed [3:0] step_c(input logic [1:0] x);
    return (x == 2'd1) ? 4'sd0 : 4'sd1;
  endfunction
  function automatic logic signed [3:0] step_r(input logic [1:0] x);
    return (x == 2'd0) ? 4'sd0 : (x == 2'd3) ? -4'sd1 : 4'sd1;
  endfunction
  assign clr = reset | logic_reset;
  assign skip = (addr_q == 3'd7) || (on_q == 6'd0);
  assign dc = step_c(d);
  assign dr = step_r(d);
  assign dc_n = step_c(d + 2'd1);
  assign dr_n = step_r(d + 2'd1);
  assign sc = neg ? -dc : dc;
  assign sr = neg ? -dr : dr;
  // Probe position is at most one step off the board, so a 4-bit signed test suffices
  assign on_board = !pos_c[3] && (pos_c[2:0] != 3'd7) && !pos_r[3] && (pos_r[2:0] < 3'd6);
  assign match = on_board && onoff_sh[pos_c[2:0]][pos_r[2:0]] && (player_sh[pos_c[2:0]][pos_r[2:0]] == pp);
  assign win_hit = (state == PROBE) && match && (cnt == 3'd3);
  assign scan_end = (state == PROBE) && !match && neg && (d == 2'd3);
  assign full = onoff_sh[0][5] & onoff_sh[1][5] & onoff_sh[2][5] & onoff_sh[3][5] &
                onoff_sh[4][5] & onoff_sh[5][5] & onoff_sh[6][5];
  always_comb begin
    p = 3'd0;
    for (int i = 0; i < 6; i++) if (on_q[i]) p = 3'(i);
  end
  always_ff @(posedge clk) state <= clr ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = logic_go ? LOAD : IDLE;
      LOAD:    next = skip ? DONE : PROBE;
      PROBE:   next = (win_hit || scan_end) ? DONE : PROBE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    logic_done = (state == DONE);
    logic_busy = (state == LOAD) || (state == PROBE);
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      onoff_sh <= '0;
      player_sh <= '0;
      logic_result <= 1'b0;
      winner <= 1'b0;
      draw <= 1'b0;
      addr_q <= '0;
      on_q <= '0;
      pl_q <= '0;
      pc <= '0;
      pr <= '0;
      pp <= 1'b0;
      pos_c <= '0;
      pos_r <= '0;
      cnt <= '0;
      d <= '0;
      neg <= 1'b0;
    end else begin
      if (state == IDLE && logic_go) begin
        addr_q <= mem_address;
        on_q <= write_to_onoff;
        pl_q <= write_to_player;
        logic_result <= 1'b0;
        winner <= 1'b0;
        draw <= 1'b0;
      end
      if (state == LOAD) begin
        if (addr_q != 3'd7) begin
          onoff_sh[addr_q] <= on_q;
          player_sh[addr_q] <= pl_q;
        end
        pc <= {1'b0, addr_q};
        pr <= {1'b0, p};
        pp <= pl_q[p];
        cnt <= 3'd1;
        d <= 2'd0;
        neg <= 1'b0;
        pos_c <= {1'b0, addr_q} + 4'sd1;
        pos_r <= {1'b0, p};
      end
      if (state == PROBE) begin
        if (match) begin
          cnt <= cnt + 3'd1;
          pos_c <= pos_c + sc;
          pos_r <= pos_r + sr;
        end else if (!neg) begin
          neg <= 1'b1;
          pos_c <= pc - dc;
          pos_r <= pr - dr;
        end else begin
          d <= d + 2'd1;
          neg <= 1'b0;
          cnt <= 3'd1;
          pos_c <= pc + dc_n;
          pos_r <= pr + dr_n;
        end
      end
      if (next == DONE) begin
        logic_result <= win_hit | (scan_end & full);
        winner <= win_hit & pp;
        draw <= scan_end & full;
      end
    end
  end
endmodule

// File: tb/tb_win_checker.sv
// tb_win_checker: table vectors, clear corner cases and random games against a board model.
module tb_win_checker;
  logic clk = 1'b0;
  logic reset = 1'b1, logic_reset = 1'b0, logic_go = 1'b0;
  logic [2:0] mem_address = '0;
  logic [5:0] write_to_onoff = '0, write_to_player = '0;
  logic logic_result, logic_done, logic_busy, winner, draw;
  int n_vec = 0, n_bad = 0;
  int occ[7][6];
  int own[7][6];
  always #5 clk = ~clk;
  win_checker dut (
    .clk(clk), .reset(reset), .logic_reset(logic_reset), .logic_go(logic_go),
    .mem_address(mem_address), .write_to_onoff(write_to_onoff), .write_to_player(write_to_player),
    .logic_result(logic_result), .logic_done(logic_done), .logic_busy(logic_busy),
    .winner(winner), .draw(draw)
  );
  typedef struct {
    bit clr;
    int a;
    logic [5:0] on;
    logic [5:0] pl;
    bit hand;
    int p;
    int res;
    int win;
    int drw;
  } vec_t;
  vec_t tbl[$];
  localparam logic [5:0] A = 6'b101010;
  localparam logic [5:0] B = 6'b010101;
  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic model_clear();
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) begin
        occ[c][r] = 0;
        own[c][r] = 0;
      end
  endtask
  // Board rules: count the run through the new piece in four line directions
  task automatic model_move(input int a, input logic [5:0] on, input logic [5:0] pl,
                            output int np, output int res, output int wn, output int dw);
    int dcs[4] = '{1, 0, 1, 1};
    int drs[4] = '{0, 1, 1, -1};
    int pc, pr, pp, cnt, c, r;
    np = 0; res = 0; wn = 0; dw = 0;
    if (a == 7) return;
    for (int i = 0; i < 6; i++) begin
      occ[a][i] = int'(on[i]);
      own[a][i] = int'(pl[i]);
    end
    if (on == 6'd0) return;
    pr = 0;
    for (int i = 0; i < 6; i++) if (on[i]) pr = i;
    pc = a;
    pp = int'(pl[pr]);
    for (int d = 0; d < 4; d++) begin
      cnt = 1;
      for (int s = 1; s >= -1; s -= 2)
        for (int k = 1; k < 8; k++) begin
          c = pc + s * k * dcs[d];
          r = pr + s * k * drs[d];
          np++;
          if (c >= 0 && c < 7 && r >= 0 && r < 6 && occ[c][r] == 1 && own[c][r] == pp) begin
            cnt++;
            if (cnt == 4) begin
              res = 1;
              wn = pp;
              return;
            end
          end else break;
        end
    end
    dw = 1;
    for (int i = 0; i < 7; i++) if (occ[i][5] == 0) dw = 0;
    res = dw;
  endtask
  task automatic clear_board();
    logic_reset = 1'b1;
    @(posedge clk); #1;
    logic_reset = 1'b0;
    model_clear();
  endtask
  task automatic do_move(input string tag, input int a, input logic [5:0] on, input logic [5:0] pl,
                         input bit hand, input int xp, input int xr, input int xw, input int xd,
                         output int got_res);
    int mp, mr, mw, md, ep, er, ew, ed, cyc, busy_n;
    model_move(a, on, pl, mp, mr, mw, md);
    ep = hand ? xp : mp;
    er = hand ? xr : mr;
    ew = hand ? xw : mw;
    ed = hand ? xd : md;
    got_res = er;
    logic_go = 1'b1;
    mem_address = a[2:0];
    write_to_onoff = on;
    write_to_player = pl;
    @(posedge clk); #1;
    logic_go = 1'b0;
    check({tag, ".load_busy"}, int'(logic_busy), 1);
    check({tag, ".load_result"}, int'(logic_result), 0);
    cyc = 1;
    busy_n = 0;
    while (!logic_done && cyc < 40) begin
      busy_n += int'(logic_busy);
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".latency"}, cyc, ep + 2);
    check({tag, ".busy_cycles"}, busy_n, ep + 1);
    check({tag, ".result"}, int'(logic_result), er);
    check({tag, ".draw"}, int'(draw), ed);
    if (er == 1 && ed == 0) check({tag, ".winner"}, int'(winner), ew);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, int'(logic_done), 0);
    check({tag, ".held"}, int'(logic_result), er);
  endtask
  initial begin
    int res, h, a;
    logic [5:0] on, pl;
    tbl.push_back('{1, 3, 6'b000001, 6'b000000, 1, 8, 0, 0, 0});
    tbl.push_back('{1, 2, 6'b000001, 6'b000001, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 2, 6'b000011, 6'b000011, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 2, 6'b000111, 6'b000111, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 2, 6'b001111, 6'b001111, 1, 6, 1, 1, 0});
    tbl.push_back('{1, 0, 6'b000001, 6'b000000, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 6'b000001, 6'b000000, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 3, 6'b000001, 6'b000000, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 2, 6'b000001, 6'b000000, 1, 4, 1, 0, 0});
    tbl.push_back('{1, 0, 6'b001111, 6'b001000, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 2, 6'b000011, 6'b000010, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 3, 6'b000001, 6'b000001, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 6'b000111, 6'b000100, 1, 10, 1, 1, 0});
    tbl.push_back('{1, 7, 6'b111111, 6'b111111, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 4, 6'b000000, 6'b000000, 1, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 6'b111111, A, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 6'b111111, A, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 2, 6'b111111, B, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 4, 6'b111111, A, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 5, 6'b111111, A, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 6, 6'b111111, B, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 3, 6'b111111, B, 1, 10, 1, 0, 1});
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset.result", int'(logic_result), 0);
    check("reset.done", int'(logic_done), 0);
    check("reset.busy", int'(logic_busy), 0);
    check("reset.winner", int'(winner), 0);
    check("reset.draw", int'(draw), 0);
    foreach (tbl[i]) begin
      if (tbl[i].clr) clear_board();
      do_move($sformatf("v%0d", i), tbl[i].a, tbl[i].on, tbl[i].pl, tbl[i].hand,
              tbl[i].p, tbl[i].res, tbl[i].win, tbl[i].drw, res);
    end
    // Clear during the third probe cycle, on the full board left by the draw
    logic_go = 1'b1;
    mem_address = 3'd3;
    write_to_onoff = 6'b000001;
    write_to_player = 6'b000000;
    @(posedge clk); #1;
    logic_go = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("clr.scanning", int'(logic_busy), 1);
    logic_reset = 1'b1;
    @(posedge clk); #1;
    logic_reset = 1'b0;
    check("clr.busy", int'(logic_busy), 0);
    check("clr.done", int'(logic_done), 0);
    check("clr.result", int'(logic_result), 0);
    check("clr.draw", int'(draw), 0);
    model_clear();
    logic_go = 1'b1;
    logic_reset = 1'b1;
    @(posedge clk); #1;
    logic_go = 1'b0;
    logic_reset = 1'b0;
    check("clr_go.busy0", int'(logic_busy), 0);
    @(posedge clk); #1;
    check("clr_go.busy1", int'(logic_busy), 0);
    do_move("clr.lone", 3, 6'b000001, 6'b000000, 1, 8, 0, 0, 0, res);
    clear_board();
    for (int n = 0; n < 80; n++) begin
      h = $urandom_range(0, 19);
      if (h == 0) begin
        do_move($sformatf("r%0d", n), 7, 6'($urandom), 6'($urandom), 0, 0, 0, 0, 0, res);
      end else if (h == 1) begin
        do_move($sformatf("r%0d", n), $urandom_range(0, 6), 6'd0, 6'd0, 0, 0, 0, 0, 0, res);
      end else begin
        a = $urandom_range(0, 6);
        for (int t = 0; t < 7 && occ[a][5] == 1; t++) a = (a + 1) % 7;
        h = 0;
        for (int r = 0; r < 6; r++) if (occ[a][r] == 1) h = r + 1;
        on = '0;
        pl = '0;
        for (int r = 0; r < h; r++) begin
          on[r] = 1'b1;
          pl[r] = own[a][r][0];
        end
        on[h] = 1'b1;
        pl[h] = 1'($urandom_range(0, 1));
        do_move($sformatf("r%0d", n), a, on, pl, 0, 0, 0, 0, 0, res);
      end
      if (res == 1) clear_board();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
